join_vector: RTL and testbench

- Gathers the 4-lane ALU results streamed slice by slice and reassembles them into one full V-element result vector for register-file write-back.
- It is the inverse of the lane fork, which splits a 20-element vector into 4 lanes over 5 beats.
- Lane l at beat k maps to vector element l*S+k.
- Sits between the lane ALUs and the vector register-file write port.
- Asserts a one-cycle done/write-enable pulse when the vector is complete.

---
 rtl/vec_pkg.sv | 20 ++
 rtl/join_vector_if.sv | 34 +++
 rtl/join_vector_beat_counter.sv | 27 ++
 rtl/join_vector.sv | 108 ++++++++++
 tb/tb_join_vector.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/vec_pkg.sv
// Shared vector definitions for the lane fork/join pair.
// Holds the element width, the vector length, the lane count and the
// number of beats per vector. It also defines the lane-slice and
// full-vector types and the join FSM state encoding.
package vec_pkg;
    localparam int N  = 32;          // element width in bits
    localparam int V  = 20;          // elements per vector
    localparam int L  = 4;           // parallel lanes
    localparam int S  = V / L;       // beats per vector
    localparam int BW = $clog2(S);   // beat index width

    typedef logic [L-1:0][N-1:0] lane_vec_t;
    typedef logic [V-1:0][N-1:0] full_vec_t;

    typedef enum logic [1:0] {
        J_IDLE,
        J_COLLECT,
        J_DONE
    } join_state_t;
endpackage

// File: rtl/join_vector_if.sv
// Bus between the lane ALUs/sequencer and the join_vector gatherer.
//
// Handshake: the slave (join_vector) captures Lane_Res_i on a rising edge
// only while it is in COLLECT (Busy_o=1) and Lane_Valid_i=1. There is no
// back-pressure: while COLLECT is active, every valid beat is accepted on
// the edge where it is presented. Start_i is sampled only in IDLE or DONE.
// Done_o is a one-cycle pulse. Result_VEC_o is complete and stable from
// that cycle until the next COLLECT writes.
//
// Signals: Start_i, Lane_Valid_i, Lane_Res_i (master -> slave);
//          Result_VEC_o, Beat_o, Busy_o, Done_o, state (slave -> master).
//          state is the FSM state, exposed for observation.
interface join_vector_if;
    import vec_pkg::*;

    logic             Start_i;
    logic             Lane_Valid_i;
    lane_vec_t        Lane_Res_i;
    full_vec_t        Result_VEC_o;
    logic [BW-1:0]    Beat_o;
    logic             Busy_o;
    logic             Done_o;
    join_state_t      state;

    modport master (
        output Start_i, Lane_Valid_i, Lane_Res_i,
        input  Result_VEC_o, Beat_o, Busy_o, Done_o, state
    );

    modport slave (
        input  Start_i, Lane_Valid_i, Lane_Res_i,
        output Result_VEC_o, Beat_o, Busy_o, Done_o, state
    );
endinterface

// File: rtl/join_vector_beat_counter.sv
// Modulo-S beat counter used by join_vector.
// Ports: clk, rst_n (async active-low), clr (synchronous clear to 0),
//        en (advance one beat), count (current beat index),
//        last (count is at S-1; the next enabled edge wraps to 0).
module beat_counter
    import vec_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    output logic [BW-1:0] count,
    output logic          last
);
    assign last = (count == BW'(S - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            // Wrapping happens only from S-1, so count never reaches S.
            count <= last ? '0 : count + 1'b1;
        end
    end
endmodule

// File: rtl/join_vector.sv
// join_vector: reassembles L-lane ALU results, streamed over S beats, into
// one V-element vector for register-file write-back. Lane l at beat k lands
// in element l*S+k. Done_o pulses for one cycle when the vector is complete.
// Ports: CLK (rising edge), RST (async active-low),
//        bus (join_vector_if.slave: start/valid/lane data in;
//             vector, beat index, busy, done and FSM state out).
module join_vector
    import vec_pkg::*;
(
    input  logic          CLK,
    input  logic          RST,
    join_vector_if.slave  bus
);
    join_state_t          state;
    join_state_t          state_next;
    logic                 cnt_clr;
    logic                 cnt_en;
    logic                 cnt_last;
    logic [BW-1:0]        beat;
    logic                 wr;
    logic [S-1:0][N-1:0]  seg_all [L];

    beat_counter u_beat_counter (
        .clk   (CLK),
        .rst_n (RST),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (beat),
        .last  (cnt_last)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= J_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        bus.Busy_o  = 1'b0;
        bus.Done_o  = 1'b0;
        case (state)
            J_IDLE: begin
                if (bus.Start_i) begin
                    cnt_clr    = 1'b1;
                    state_next = J_COLLECT;
                end
            end
            J_COLLECT: begin
                // Start_i is deliberately ignored here: no mid-vector restart.
                bus.Busy_o = 1'b1;
                if (bus.Lane_Valid_i) begin
                    cnt_en = 1'b1;
                    if (cnt_last) begin
                        state_next = J_DONE;
                    end
                end
            end
            J_DONE: begin
                bus.Done_o = 1'b1;
                if (bus.Start_i) begin
                    cnt_clr    = 1'b1;
                    state_next = J_COLLECT;
                end else begin
                    state_next = J_IDLE;
                end
            end
            default: begin
                state_next = J_IDLE;
            end
        endcase
    end

    assign wr = (state == J_COLLECT) && bus.Lane_Valid_i;

    // Each lane owns the contiguous element segment [l*S, l*S+S-1]. The beat
    // index selects the element inside that segment. Elements keep their
    // previous values until overwritten; nothing is cleared at Start_i.
    for (genvar l = 0; l < L; l++) begin : lane_g
        logic [S-1:0][N-1:0] seg;

        always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
                seg <= '0;
            end else if (wr) begin
                seg[beat] <= bus.Lane_Res_i[l];
            end
        end

        assign seg_all[l] = seg;
    end

    always_comb begin
        bus.Result_VEC_o = '0;
        for (int l = 0; l < L; l++) begin
            for (int k = 0; k < S; k++) begin
                bus.Result_VEC_o[l*S + k] = seg_all[l][k];
            end
        end
    end

    assign bus.Beat_o = beat;
    assign bus.state  = state;
endmodule

// File: tb/tb_join_vector.sv
// Self-checking bench for join_vector: directed scenarios plus randomized
// vectors, checked against a beat-list reference model.
module tb_join_vector;
    import vec_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    join_vector_if bus ();

    join_vector dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    // Accepted beats of the vector in flight, in arrival order.
    logic [L*N-1:0] exp_q[$];
    full_vec_t      exp_vec;

    task automatic check(input string tag, input logic [V*N-1:0] obs,
                         input logic [V*N-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle. Outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
        check("beat_range", bus.Beat_o < S, 1);
        check("done_busy_excl", bus.Done_o & bus.Busy_o, 0);
    endtask

    // Reference model: beat k of lane l lands in element l*S+k.
    // Elements not delivered keep their previous values.
    function automatic full_vec_t model_gather(input full_vec_t prev);
        full_vec_t      v;
        logic [L*N-1:0] b;
        v = prev;
        for (int k = 0; k < S; k++) begin
            if (exp_q.size() > 0) begin
                b = exp_q.pop_front();
                for (int l = 0; l < L; l++) v[l*S + k] = b[l*N +: N];
            end
        end
        return v;
    endfunction

    // Presents Start_i in the current cycle, then S beats with the given
    // stall cycles before each beat. It returns when Done_o is seen (or the
    // wait budget is exhausted). lat counts cycles from the Start_i cycle (0).
    task automatic gather(input lane_vec_t beats[S], input int stalls[S],
                          input bit start_mid, output int lat);
        int n;
        bus.Start_i      = 1'b1;
        bus.Lane_Valid_i = 1'b0;
        tick();
        bus.Start_i = 1'b0;
        lat = 1;
        check("enter_collect", bus.state, J_COLLECT);
        check("busy_collect", bus.Busy_o, 1);
        check("beat_start", bus.Beat_o, 0);
        for (int k = 0; k < S; k++) begin
            for (int s = 0; s < stalls[k]; s++) begin
                bus.Lane_Valid_i = 1'b0;
                bus.Lane_Res_i   = {$urandom, $urandom, $urandom, $urandom};
                tick();
                lat++;
                check("stall_hold", bus.Beat_o, k);
            end
            bus.Lane_Valid_i = 1'b1;
            bus.Lane_Res_i   = beats[k];
            bus.Start_i      = start_mid && (k == 3);
            exp_q.push_back(beats[k]);
            tick();
            lat++;
            bus.Start_i      = 1'b0;
            bus.Lane_Valid_i = 1'b0;
            if (k < S - 1) check("beat_advance", bus.Beat_o, k + 1);
        end
        n = 0;
        while (!bus.Done_o && n < 10) begin
            tick();
            lat++;
            n++;
        end
        check("done_seen", bus.Done_o, 1);
        exp_vec = model_gather(exp_vec);
        check("vector", bus.Result_VEC_o, exp_vec);
        check("beat_done", bus.Beat_o, 0);
        check("state_done", bus.state, J_DONE);
    endtask

    task automatic idle_after_done();
        bus.Start_i = 1'b0;
        tick();
        check("done_pulse_one", bus.Done_o, 0);
        check("state_idle", bus.state, J_IDLE);
    endtask

    initial begin
        lane_vec_t beats[S];
        int        stalls[S];
        int        lat;
        int        tot;
        int        done_cnt;
        bit        b2b;

        exp_vec = '0;
        // Reset held with active inputs.
        bus.Start_i      = 1'b1;
        bus.Lane_Valid_i = 1'b1;
        bus.Lane_Res_i   = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_vec", bus.Result_VEC_o, 0);
            check("rst_beat", bus.Beat_o, 0);
            check("rst_busy", bus.Busy_o, 0);
            check("rst_done", bus.Done_o, 0);
        end
        RST              = 1'b1;
        bus.Start_i      = 1'b0;
        bus.Lane_Valid_i = 1'b0;
        tick();
        check("post_rst_idle", bus.state, J_IDLE);

        // Basic gather: lane l beat k = 100*l+k.
        for (int k = 0; k < S; k++) begin
            for (int l = 0; l < L; l++) beats[k][l] = N'(100*l + k);
            stalls[k] = 0;
        end
        gather(beats, stalls, 1'b0, lat);
        check("basic_latency", lat, S + 1);
        check("elem7", bus.Result_VEC_o[7], 102);
        check("elem19", bus.Result_VEC_o[19], 304);
        for (int j = 0; j < V; j++)
            check("basic_elem", bus.Result_VEC_o[j], 100*(j/5) + (j%5));
        idle_after_done();

        // Lane_Valid_i in IDLE is ignored.
        bus.Lane_Valid_i = 1'b1;
        bus.Lane_Res_i   = {L{32'hDEAD}};
        tick();
        tick();
        bus.Lane_Valid_i = 1'b0;
        check("idle_ignore_vec", bus.Result_VEC_o, exp_vec);
        check("idle_ignore_state", bus.state, J_IDLE);

        // Stall: two idle cycles after beat 2.
        stalls[3] = 2;
        gather(beats, stalls, 1'b0, lat);
        check("stall_latency", lat, S + 3);
        idle_after_done();
        stalls[3] = 0;

        // Start_i at beat 3 is ignored, then back-to-back with 0xA0+k.
        gather(beats, stalls, 1'b1, lat);
        check("start_mid_latency", lat, S + 1);
        for (int k = 0; k < S; k++) beats[k] = {L{N'(32'hA0 + k)}};
        gather(beats, stalls, 1'b0, lat);
        check("b2b_latency", lat, S + 1);
        for (int j = 0; j < V; j++)
            check("b2b_elem", bus.Result_VEC_o[j], 32'hA0 + (j % S));
        idle_after_done();

        // Randomized vectors with random stalls and random back-to-back.
        b2b = 1'b0;
        for (int t = 0; t < 8; t++) begin
            tot = 0;
            for (int k = 0; k < S; k++) begin
                beats[k]  = {$urandom, $urandom, $urandom, $urandom};
                stalls[k] = $urandom_range(0, 2);
                tot += stalls[k];
            end
            gather(beats, stalls, 1'($urandom_range(0, 1)), lat);
            check("rand_latency", lat, S + 1 + tot);
            b2b = 1'($urandom_range(0, 1));
            if (!b2b) idle_after_done();
        end
        if (b2b) idle_after_done();

        // Asynchronous reset between edges after beat 2.
        bus.Start_i = 1'b1;
        tick();
        bus.Start_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.Lane_Valid_i = 1'b1;
            bus.Lane_Res_i   = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        bus.Lane_Valid_i = 1'b0;
        check("pre_rst_beat", bus.Beat_o, 3);
        #2;
        RST = 1'b0;
        #1;
        check("async_vec", bus.Result_VEC_o, 0);
        check("async_state", bus.state, J_IDLE);
        check("async_beat", bus.Beat_o, 0);
        check("async_busy", bus.Busy_o, 0);
        check("async_done", bus.Done_o, 0);
        exp_q.delete();
        exp_vec = '0;
        tick();
        RST = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            bus.Lane_Valid_i = 1'b1;
            bus.Lane_Res_i   = {$urandom, $urandom, $urandom, $urandom};
            tick();
            if (bus.Done_o) done_cnt++;
        end
        bus.Lane_Valid_i = 1'b0;
        check("no_done_after_rst", done_cnt, 0);
        check("vec_zero_after_rst", bus.Result_VEC_o, exp_vec);
        check("idle_after_rst", bus.state, J_IDLE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
